operand_sram_resp: RTL and testbench
====================================

OPERAND_SRAM_RESP -- requirements
Module: operand_sram_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning the number of 32-bit words in the operand SRAM.
REQ-002 SHALL have parameter AW, default 8, meaning the SRAM word-index width, equal to log2(DEPTH).
REQ-003 SHALL have parameter FQ, default 4, meaning the response FIFO depth per channel.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 datatype  in  params::datatype_t  operand type (FP32/FP16/INT8/INT4), sampled with each request.
REQ-007 wr_en  in  1  operand load strobe.
REQ-008 wr_addr  in  AW  load word index.
REQ-009 wr_data  in  32  load word.
REQ-010 req_en  in  1  read request for both channels, driven by the address generator's en_out.
REQ-011 req_addr_A, req_addr_B  in  32 each  request addresses in halfword units; SRAM word index = addr[AW:1].
REQ-012 cm_in  in  1  drain request, driven by the address generator's cmen_out.
REQ-013 req_ready  out  1  credit available; a request is accepted only when req_en and req_ready are both high.
REQ-014 rsp_valid  out  1  A/B response pair available.
REQ-015 rsp_ready  in  1  consumer pops one A/B pair when rsp_valid and rsp_ready are both high.
REQ-016 rsp_data_A, rsp_data_B  out  32 each  extracted operand words.
REQ-017 rsp_err_A, rsp_err_B  out  1 each  request address was out of range.
REQ-018 done_out  out  1  one-cycle pulse when a drain completes.

Function
REQ-019 SHALL hold a single DEPTH x 32 array with one write port and two read ports, A and B; contents SHALL NOT be reset.
REQ-020 Write and read of the same word on the same edge SHALL return the old data (read-first).
REQ-021 Pipeline:
- Edge 1 after acceptance: both words read into stage register S1, latching addr[0], datatype and the err flag per channel.
- Edge 2: the extracted pair is pushed into the shared FIFO.
- rsp_valid therefore rises two cycles after acceptance when the FIFO was empty.
REQ-022 req_ready SHALL equal (fifo_count + s1_valid) < FQ, computed from registers only; accepting at full credit SHALL be impossible.
REQ-023 Extraction SHALL use the latched datatype:
- FP32: full word.
- FP16: {16'b0, word[15:0]} when addr[0]=0; {16'b0, word[31:16]} when addr[0]=1.
- INT8 and INT4: full packed word; lanes are unpacked downstream.
REQ-024 err SHALL be 1 when addr[31:AW+1] is nonzero; the matching data SHALL then be 0, and the read SHALL NOT touch the array.
REQ-025 The FIFO SHALL be strictly in order. Push and pop on the same edge SHALL leave fifo_count unchanged. Pop on empty SHALL be ignored. Pointers SHALL wrap modulo FQ.
REQ-026 rsp_data_* and rsp_err_* SHALL show the FIFO head and remain stable while rsp_valid=1 and rsp_ready=0.
REQ-027 Drain behaviour:
- cm_in sets drain_pending.
- When drain_pending=1, s1_valid=0 and fifo_count=0 hold after an edge, done_out SHALL pulse high for exactly one cycle and drain_pending SHALL clear.
- cm_in while drain_pending=1 SHALL have no further effect.
REQ-028 cm_in asserted with the pipeline already empty SHALL produce done_out in the next cycle.
REQ-029 req_en and cm_in on the same edge: the request SHALL be accepted, and done_out SHALL wait for that request to be popped.

Reset
REQ-030 On rst=1 at an edge, the block SHALL clear: s1_valid, fifo_count, both FIFO pointers, drain_pending, done_out, rsp_valid, rsp_data_A/B and rsp_err_A/B.
REQ-031 Requests in flight at reset SHALL be discarded and never appear on the response side.
REQ-032 rst SHALL take priority over wr_en, req_en and cm_in on the same edge.
REQ-033 After reset, req_ready SHALL be 1 in the first cycle with rst=0.

Verification
REQ-034 Load word 5 = 0xAABBCCDD; FP32 request with A=10, B=10 and rsp_ready=1 -> rsp_valid two cycles later, data_A = data_B = 0xAABBCCDD, err = 0.
REQ-035 FP16 with A=10, B=11 on word 5 -> data_A = 0x0000CCDD, data_B = 0x0000AABB.
REQ-036 rsp_ready=0 with back-to-back requests -> exactly 4 accepted and req_ready=0. Raise rsp_ready -> 4 pairs return in order, and req_ready recovers on the first pop.
REQ-037 INT8 request with A = 0x200 (DEPTH=256) -> err_A=1, data_A=0; channel B returns normally.
REQ-038 Three requests, then cm_in, with rsp_ready held low 5 cycles -> done_out stays low until the third pair is popped, then pulses high for exactly one cycle.
REQ-039 rst asserted one cycle after a request is accepted -> no rsp_valid afterward, and req_ready=1 in the first cycle after rst deasserts.

Source files
------------

// File: rtl/operand_sram_resp_if.sv
// Request/response bundle between the address generator, the operand SRAM and its consumer.
// Pure wiring: no latency of its own.
// Flow control: req_ready is a credit gate on requests; rsp_valid/rsp_ready pop response pairs.
interface operand_sram_resp_if #(
  parameter int AW = 8
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          req_en;
  logic [31:0]   req_addr_A;
  logic [31:0]   req_addr_B;
  logic          cm_in;
  logic          req_ready;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_data_A;
  logic [31:0]   rsp_data_B;
  logic          rsp_err_A;
  logic          rsp_err_B;
  logic          done_out;

  modport master (
    output wr_en, wr_addr, wr_data, req_en, req_addr_A, req_addr_B, cm_in, rsp_ready,
    input  req_ready, rsp_valid, rsp_data_A, rsp_data_B, rsp_err_A, rsp_err_B, done_out
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, req_en, req_addr_A, req_addr_B, cm_in, rsp_ready,
    output req_ready, rsp_valid, rsp_data_A, rsp_data_B, rsp_err_A, rsp_err_B, done_out
  );
endinterface

// File: rtl/operand_sram_resp.sv
// Dual-read operand SRAM with operand extraction and an in-order A/B response FIFO plus drain detect.
// Latency: a request accepted on one edge is visible on rsp_valid two cycles after it was presented.
// Backpressure: req_ready is a credit (FIFO entries + stage-1 occupancy < FQ); responses hold while rsp_ready=0.
package params;
  typedef enum logic [1:0] {
    DT_FP32 = 2'd0,
    DT_FP16 = 2'd1,
    DT_INT8 = 2'd2,
    DT_INT4 = 2'd3
  } datatype_t;
endpackage

module operand_sram_resp #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int FQ    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  params::datatype_t  datatype,
  operand_sram_resp_if.slave bus
);
  localparam int PW = (FQ > 1) ? $clog2(FQ) : 1;
  localparam int CW = $clog2(FQ + 1);

  // Operand storage; never reset, loaded through the write port.
  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          err_a, err_b;
  logic [AW-1:0] idx_a, idx_b;

  logic              s1_valid_q, s1_valid_d;
  logic [31:0]       s1_word_a_q, s1_word_b_q;
  logic              s1_lsb_a_q, s1_lsb_b_q;
  logic              s1_err_a_q, s1_err_b_q;
  params::datatype_t s1_dt_q;
  logic [31:0]       ext_a, ext_b;

  logic [31:0]   fifo_dat_a_q [FQ];
  logic [31:0]   fifo_dat_b_q [FQ];
  logic          fifo_err_a_q [FQ];
  logic          fifo_err_b_q [FQ];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop, rsp_valid;
  logic [CW:0]   credit_used;

  logic drain_pending_q, drain_pending_d, done_q, done_d, drain_req;

  // Only FP16 needs lane selection; packed integer lanes are split downstream.
  function automatic logic [31:0] extract(input logic [31:0] w, input logic lsb,
                                          input params::datatype_t dt);
    logic [31:0] r;
    r = w;
    if (dt == params::DT_FP16) begin
      r = lsb ? {16'h0000, w[31:16]} : {16'h0000, w[15:0]};
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(FQ - 1)) ? '0 : p + PW'(1);
  endfunction

  // Request decode: halfword addresses, word index in [AW:1], anything above is out of range.
  assign idx_a       = bus.req_addr_A[AW:1];
  assign idx_b       = bus.req_addr_B[AW:1];
  assign err_a       = |bus.req_addr_A[31:AW+1];
  assign err_b       = |bus.req_addr_B[31:AW+1];
  assign credit_used = {1'b0, count_q} + {{CW{1'b0}}, s1_valid_q};
  assign bus.req_ready = credit_used < (CW+1)'(FQ);
  assign accept      = bus.req_en & bus.req_ready;
  assign s1_valid_d  = accept;

  // Operand load port; reset wins over a coincident write.
  always_ff @(posedge clk) begin
    if (!rst && bus.wr_en) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Stage 1 payload: read-first array access, skipped entirely for out-of-range addresses.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_word_a_q <= err_a ? 32'h0 : mem[idx_a];
      s1_word_b_q <= err_b ? 32'h0 : mem[idx_b];
      s1_lsb_a_q  <= bus.req_addr_A[0];
      s1_lsb_b_q  <= bus.req_addr_B[0];
      s1_err_a_q  <= err_a;
      s1_err_b_q  <= err_b;
      s1_dt_q     <= datatype;
    end
  end

  // Stage 1 occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
    end
  end

  assign ext_a     = extract(s1_word_a_q, s1_lsb_a_q, s1_dt_q);
  assign ext_b     = extract(s1_word_b_q, s1_lsb_b_q, s1_dt_q);
  assign push      = s1_valid_q;
  assign rsp_valid = (count_q != '0);
  assign pop       = rsp_valid & bus.rsp_ready;

  // FIFO bookkeeping; credit guarantees a push never meets a full FIFO.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage write of the extracted pair.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_dat_a_q[wr_ptr_q] <= ext_a;
      fifo_dat_b_q[wr_ptr_q] <= ext_b;
      fifo_err_a_q[wr_ptr_q] <= s1_err_a_q;
      fifo_err_b_q[wr_ptr_q] <= s1_err_b_q;
    end
  end

  // Head of FIFO drives the response; zero when empty so reset clears it too.
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_data_A = rsp_valid ? fifo_dat_a_q[rd_ptr_q] : 32'h0;
  assign bus.rsp_data_B = rsp_valid ? fifo_dat_b_q[rd_ptr_q] : 32'h0;
  assign bus.rsp_err_A  = rsp_valid & fifo_err_a_q[rd_ptr_q];
  assign bus.rsp_err_B  = rsp_valid & fifo_err_b_q[rd_ptr_q];

  // Drain detect: looks at post-edge occupancy so a request taken with cm_in is waited for.
  always_comb begin
    drain_req       = drain_pending_q | bus.cm_in;
    drain_pending_d = drain_req;
    done_d          = 1'b0;
    if (drain_req && !s1_valid_d && (count_d == '0)) begin
      done_d          = 1'b1;
      drain_pending_d = 1'b0;
    end
  end

  // Drain state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      drain_pending_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      drain_pending_q <= drain_pending_d;
      done_q          <= done_d;
    end
  end

  assign bus.done_out = done_q;
endmodule

// File: tb/tb_operand_sram_resp.sv
// Scoreboard bench for operand_sram_resp: reference memory + extraction model feed an expected-response queue.
// Inputs driven 1 time unit after the rising edge; everything sampled on the falling edge.
// Directed cases cover latency, FP16 lanes, credit backpressure, range errors, drain and reset.
module tb_operand_sram_resp;
  import params::*;

  logic      clk = 1'b0;
  logic      rst;
  datatype_t datatype;

  operand_sram_resp_if #(.AW(8)) bus ();

  operand_sram_resp #(.DEPTH(256), .AW(8), .FQ(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .datatype (datatype),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        ea;
    logic        eb;
  } rsp_t;

  rsp_t        sbq[$];
  logic [31:0] model_mem [256];
  int total = 0;
  int bad   = 0;
  int n_acc = 0;
  int n_pop = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] model_lane(input logic [31:0] addr, input datatype_t dt);
    logic [31:0] w;
    if (|addr[31:9]) return {1'b1, 32'h0};
    w = model_mem[addr[8:1]];
    if (dt == DT_FP16) return {1'b0, (addr[0] ? {16'h0, w[31:16]} : {16'h0, w[15:0]})};
    return {1'b0, w};
  endfunction

  // Scoreboard: compare pops, then record accepts (read-first), then apply writes.
  always @(negedge clk) begin
    rsp_t        e;
    logic [32:0] la, lb;
    if (rst) begin
      sbq.delete();
    end else begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        check("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          check("rsp_data_A", bus.rsp_data_A, e.a);
          check("rsp_data_B", bus.rsp_data_B, e.b);
          check("rsp_err_A", 32'(bus.rsp_err_A), 32'(e.ea));
          check("rsp_err_B", 32'(bus.rsp_err_B), 32'(e.eb));
        end
        n_pop++;
      end
      if (bus.req_en && bus.req_ready) begin
        la = model_lane(bus.req_addr_A, datatype);
        lb = model_lane(bus.req_addr_B, datatype);
        e.a = la[31:0]; e.ea = la[32];
        e.b = lb[31:0]; e.eb = lb[32];
        sbq.push_back(e);
        n_acc++;
      end
      if (bus.wr_en) model_mem[bus.wr_addr] = bus.wr_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_en = 1'b0;
    bus.cm_in  = 1'b0;
    bus.wr_en  = 1'b0;
  endtask

  task automatic req(input datatype_t dt, input logic [31:0] a, input logic [31:0] b);
    datatype       = dt;
    bus.req_en     = 1'b1;
    bus.req_addr_A = a;
    bus.req_addr_B = b;
  endtask

  task automatic wait_rsp(input string tag);
    @(negedge clk);
    for (int i = 0; i < 20 && !bus.rsp_valid; i++) @(negedge clk);
    check(tag, 32'(bus.rsp_valid), 32'd1);
  endtask

  // Watch ncyc cycles with rsp_ready high; report done pulses and pops seen at the pulse.
  task automatic watch_done(input int ncyc, output int pulses, output int pops_at_done);
    int p0;
    p0 = n_pop;
    pulses = 0;
    pops_at_done = -1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (bus.done_out) begin
        pulses++;
        pops_at_done = n_pop - p0;
      end
      step();
    end
  endtask

  initial begin
    int a0, p0, pulses, pops;
    bit seen;
    logic [31:0] ra, rb;

    rst = 1'b1;
    datatype = DT_FP32;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.req_en = 1'b0; bus.req_addr_A = '0; bus.req_addr_B = '0;
    bus.cm_in = 1'b0; bus.rsp_ready = 1'b0;
    repeat (2) step();
    @(negedge clk);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_done", 32'(bus.done_out), 32'd0);
    check("rst_data_A", bus.rsp_data_A, 32'h0);
    check("rst_err_A", 32'(bus.rsp_err_A), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    step();

    // Preload all words.
    for (int i = 0; i < 256; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_addr = 8'(i);
      bus.wr_data = (i == 5) ? 32'hAABBCCDD : $urandom;
      step();
    end
    idle();

    // FP32 latency and data.
    bus.rsp_ready = 1'b1;
    req(DT_FP32, 32'd10, 32'd10); step(); idle();
    @(negedge clk); check("fp32_valid_c1", 32'(bus.rsp_valid), 32'd0);
    step();
    @(negedge clk); check("fp32_valid_c2", 32'(bus.rsp_valid), 32'd1);
    check("fp32_A", bus.rsp_data_A, 32'hAABBCCDD);
    check("fp32_B", bus.rsp_data_B, 32'hAABBCCDD);
    check("fp32_errA", 32'(bus.rsp_err_A), 32'd0);
    step();

    // FP16 lane select.
    req(DT_FP16, 32'd10, 32'd11); step(); idle();
    wait_rsp("fp16_valid");
    check("fp16_A", bus.rsp_data_A, 32'h0000CCDD);
    check("fp16_B", bus.rsp_data_B, 32'h0000AABB);
    step();

    // Credit backpressure.
    bus.rsp_ready = 1'b0;
    a0 = n_acc;
    for (int i = 0; i < 8; i++) begin
      req(DT_FP32, 32'(2 * (40 + i)), 32'(2 * (60 + i) + 1)); step();
    end
    idle();
    @(negedge clk);
    check("bp_accepted", 32'(n_acc - a0), 32'd4);
    check("bp_ready_low", 32'(bus.req_ready), 32'd0);
    step();
    bus.rsp_ready = 1'b1;
    p0 = n_pop;
    step();
    @(negedge clk); check("bp_ready_recover", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < 20 && (n_pop - p0) < 4; i++) step();
    check("bp_pops", 32'(n_pop - p0), 32'd4);
    step();

    // Out-of-range address on channel A.
    req(DT_INT8, 32'h200, 32'd40); step(); idle();
    wait_rsp("err_valid");
    check("err_A", 32'(bus.rsp_err_A), 32'd1);
    check("err_data_A", bus.rsp_data_A, 32'h0);
    check("err_B", 32'(bus.rsp_err_B), 32'd0);
    check("err_data_B", bus.rsp_data_B, model_mem[20]);
    step();

    // Drain with three pairs held back.
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req(DT_FP32, 32'(2 * (70 + i)), 32'(2 * (80 + i))); step();
    end
    idle();
    bus.cm_in = 1'b1; step(); bus.cm_in = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.done_out) seen = 1'b1;
      step();
    end
    check("drain_hold_done", 32'(seen), 32'd0);
    bus.rsp_ready = 1'b1;
    watch_done(12, pulses, pops);
    check("drain_pulses", 32'(pulses), 32'd1);
    check("drain_pops_at_done", 32'(pops), 32'd3);

    // Drain with empty pipeline.
    bus.cm_in = 1'b1; step(); bus.cm_in = 1'b0;
    @(negedge clk); check("empty_drain_done", 32'(bus.done_out), 32'd1);
    step();
    @(negedge clk); check("empty_drain_once", 32'(bus.done_out), 32'd0);
    step();

    // Request and drain on the same edge.
    bus.rsp_ready = 1'b0;
    req(DT_FP32, 32'd100, 32'd102); bus.cm_in = 1'b1; step(); idle();
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.done_out) seen = 1'b1;
      step();
    end
    check("same_edge_hold", 32'(seen), 32'd0);
    bus.rsp_ready = 1'b1;
    watch_done(8, pulses, pops);
    check("same_edge_pulses", 32'(pulses), 32'd1);
    check("same_edge_pops", 32'(pops), 32'd1);

    // Reset one cycle after acceptance; also try a write to word 5 under reset.
    req(DT_FP32, 32'd60, 32'd62); step(); idle();
    rst = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 8'd5; bus.wr_data = 32'h12345678; bus.cm_in = 1'b1;
    step();
    rst = 1'b0; idle();
    @(negedge clk);
    check("post_rst_ready", 32'(bus.req_ready), 32'd1);
    check("post_rst_done", 32'(bus.done_out), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.rsp_valid) seen = 1'b1;
      step();
      @(negedge clk);
    end
    check("post_rst_no_valid", 32'(seen), 32'd0);
    step();
    req(DT_FP32, 32'd10, 32'd10); step(); idle();
    wait_rsp("rst_wr_valid");
    check("rst_wr_blocked", bus.rsp_data_A, 32'hAABBCCDD);
    step();

    // Random traffic with frequent write/read collisions.
    for (int i = 0; i < 300; i++) begin
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      bus.req_en = 1'($urandom_range(0, 1));
      datatype = datatype_t'($urandom_range(0, 3));
      ra = 32'($urandom_range(0, 31));
      rb = 32'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) ra = ra | 32'h0001_0000;
      if ($urandom_range(0, 7) == 0) rb = rb | 32'h8000_0000;
      bus.req_addr_A = ra;
      bus.req_addr_B = rb;
      bus.wr_en = ($urandom_range(0, 2) == 0);
      bus.wr_addr = 8'($urandom_range(0, 15));
      bus.wr_data = $urandom;
      step();
    end
    idle();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 20 && sbq.size() != 0; i++) step();
    check("sb_drained", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
